// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V counters, a fetch-coordinate stage, and a
// display-aligned copy of the decode delayed a further P_FETCH_LEAD cycles.
module vga_timing_gen #(
    parameter int P_H_VISIBLE     = 640,
    parameter int P_H_FRONT_PORCH = 16,
    parameter int P_H_SYNC_PULSE  = 96,
    parameter int P_H_BACK_PORCH  = 48,
    parameter int P_V_VISIBLE     = 480,
    parameter int P_V_FRONT_PORCH = 10,
    parameter int P_V_SYNC_PULSE  = 2,
    parameter int P_V_BACK_PORCH  = 33,
    parameter int P_H_SYNC_POL    = 0,
    parameter int P_V_SYNC_POL    = 0,
    parameter int P_FETCH_LEAD    = 2,
    parameter int P_FRAME_BITS    = 8
) (
    input  logic                               i_VGA_CLOCK,
    input  logic                               i_RESET_N,
    input  logic                               i_ENABLE,
    output logic                               o_FETCH_VALID,
    output logic [$clog2(P_H_VISIBLE)-1:0]     o_FETCH_X,
    output logic [$clog2(P_V_VISIBLE)-1:0]     o_FETCH_Y,
    output logic                               o_VGA_SYNC_H,
    output logic                               o_VGA_SYNC_V,
    output logic                               o_DRAW_ENABLE,
    output logic [$clog2(P_H_VISIBLE)-1:0]     o_SCANLINE_X,
    output logic [$clog2(P_V_VISIBLE)-1:0]     o_SCANLINE_Y,
    output logic                               o_LINE_START,
    output logic                               o_FRAME_START,
    output logic                               o_VBLANK,
    output logic [P_FRAME_BITS-1:0]            o_FRAME_COUNT
);

    localparam int H_TOTAL = P_H_VISIBLE + P_H_FRONT_PORCH + P_H_SYNC_PULSE + P_H_BACK_PORCH;
    localparam int V_TOTAL = P_V_VISIBLE + P_V_FRONT_PORCH + P_V_SYNC_PULSE + P_V_BACK_PORCH;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(P_H_VISIBLE);
    localparam int YW = $clog2(P_V_VISIBLE);

    // Thresholds carry one spare bit so a sync pulse ending exactly at the
    // total count cannot wrap to zero.
    localparam logic [HW:0]   H_VIS_END  = (HW+1)'(P_H_VISIBLE);
    localparam logic [HW:0]   H_SYNC_BEG = (HW+1)'(P_H_VISIBLE + P_H_FRONT_PORCH);
    localparam logic [HW:0]   H_SYNC_END = (HW+1)'(P_H_VISIBLE + P_H_FRONT_PORCH + P_H_SYNC_PULSE);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW:0]   V_VIS_END  = (VW+1)'(P_V_VISIBLE);
    localparam logic [VW:0]   V_SYNC_BEG = (VW+1)'(P_V_VISIBLE + P_V_FRONT_PORCH);
    localparam logic [VW:0]   V_SYNC_END = (VW+1)'(P_V_VISIBLE + P_V_FRONT_PORCH + P_V_SYNC_PULSE);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    localparam logic H_ACT = 1'(P_H_SYNC_POL);
    localparam logic V_ACT = 1'(P_V_SYNC_POL);

    typedef struct packed {
        logic          visible;
        logic          sync_h;
        logic          sync_v;
        logic          line_start;
        logic          frame_start;
        logic          vblank;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } stage_t;

    // Sync levels are stored already polarised so every output is a plain flop.
    localparam stage_t STAGE_IDLE = '{
        visible: 1'b0, sync_h: ~H_ACT, sync_v: ~V_ACT,
        line_start: 1'b0, frame_start: 1'b0, vblank: 1'b0,
        x: '0, y: '0
    };

    logic [HW-1:0]           h;
    logic [VW-1:0]           v;
    logic [P_FRAME_BITS-1:0] frame_count;
    stage_t                  dec;
    stage_t                  pipe [0:P_FETCH_LEAD];

    logic h_vis, v_vis, h_sync, v_sync;

    assign h_vis  = {1'b0, h} < H_VIS_END;
    assign v_vis  = {1'b0, v} < V_VIS_END;
    assign h_sync = ({1'b0, h} >= H_SYNC_BEG) && ({1'b0, h} < H_SYNC_END);
    assign v_sync = ({1'b0, v} >= V_SYNC_BEG) && ({1'b0, v} < V_SYNC_END);

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge i_VGA_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            h           <= '0;
            v           <= '0;
            frame_count <= '0;
        end else if (!i_ENABLE) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            if (v == V_LAST) begin
                v           <= '0;
                frame_count <= frame_count + 1'b1;
            end else begin
                v <= v + 1'b1;
            end
        end else begin
            h <= h + 1'b1;
        end
    end

    // NOTE: dec gets a full default before any condition, so no path through
    // this block leaves a field unassigned and no latch is inferred.
    always_comb begin
        dec = STAGE_IDLE;
        if (i_ENABLE) begin
            dec.visible     = h_vis && v_vis;
            dec.sync_h      = h_sync ? H_ACT : ~H_ACT;
            dec.sync_v      = v_sync ? V_ACT : ~V_ACT;
            dec.line_start  = (h == '0);
            dec.frame_start = (h == '0) && (v == '0);
            dec.vblank      = !v_vis;
            if (h_vis && v_vis) begin
                dec.x = h[XW-1:0];
                dec.y = v[YW-1:0];
            end
        end
    end

    // NOTE: the delay line is a few flops rather than a RAM, so it is reset
    // with everything else; outputs must read idle the instant reset asserts.
    always_ff @(posedge i_VGA_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            for (int i = 0; i <= P_FETCH_LEAD; i++) pipe[i] <= STAGE_IDLE;
        end else begin
            pipe[0] <= dec;
            for (int i = 1; i <= P_FETCH_LEAD; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign o_FETCH_VALID = pipe[0].visible;
    assign o_FETCH_X     = pipe[0].x;
    assign o_FETCH_Y     = pipe[0].y;

    assign o_DRAW_ENABLE = pipe[P_FETCH_LEAD].visible;
    assign o_VGA_SYNC_H  = pipe[P_FETCH_LEAD].sync_h;
    assign o_VGA_SYNC_V  = pipe[P_FETCH_LEAD].sync_v;
    assign o_SCANLINE_X  = pipe[P_FETCH_LEAD].x;
    assign o_SCANLINE_Y  = pipe[P_FETCH_LEAD].y;
    assign o_LINE_START  = pipe[P_FETCH_LEAD].line_start;
    assign o_FRAME_START = pipe[P_FETCH_LEAD].frame_start;
    assign o_VBLANK      = pipe[P_FETCH_LEAD].vblank;
    assign o_FRAME_COUNT = frame_count;

endmodule
